// File: rtl/dvl_pkg.sv
// Shared types and helpers for the multi-channel data-valid gate generator.
//  - dvl_state_e : per-channel gate FSM state (IDLE, VALID, HOLD)
//  - hold_w()    : width of the hold-off counter for a given HOLDOFF value
package dvl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        VALID = 2'd1,
        HOLD  = 2'd2
    } dvl_state_e;

    // clog2(HOLDOFF+1), kept at least 1 bit so HOLDOFF==0 still yields a legal vector
    function automatic int unsigned hold_w(input int unsigned holdoff);
        return (holdoff == 0) ? 1 : $clog2(holdoff + 1);
    endfunction

endpackage

// File: rtl/dvl_channel.sv
// One data-valid gate channel: IDLE/VALID/HOLD FSM with gate length, hold-off
// and gate counters plus an optional sticky watchdog flag.
// Optional feature: DVL_TIMEOUT_EN enables the watchdog close at MAX_GATE.
// Ports:
//  clk, reset_i           clock, asynchronous active-high reset
//  i_enable               arm; low blocks new gates only
//  i_start, i_end         gate open / close requests
//  i_clear                synchronous clear of gate counter and timeout flag
//  o_data_valid           registered gate
//  o_data_valid_next_c    combinational next-state gate (feeds the top-level OR register)
//  o_gate_cnt             gates opened, wraps at 2**CNT_W
//  o_timeout              sticky watchdog flag (0 when the watchdog is not built)
module dvl_channel
    import dvl_pkg::*;
#(
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned MIN_GATE = 0,
    parameter int unsigned HOLDOFF  = 2,
    parameter int unsigned MAX_GATE = 65535,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             i_enable,
    input  logic             i_start,
    input  logic             i_end,
    input  logic             i_clear,
    output logic             o_data_valid,
    output logic             o_data_valid_next_c,
    output logic [CNT_W-1:0] o_gate_cnt,
    output logic             o_timeout
);

    localparam int unsigned HOLD_W = hold_w(HOLDOFF);

    dvl_state_e        r_state;
    dvl_state_e        w_state_nxt;
    logic [LEN_W-1:0]  r_len;
    logic [LEN_W-1:0]  w_len_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_dv;
    logic              w_dv_nxt;
    logic              w_len_ok;
    logic              w_close;

    // end_i is honoured only once the gate has been open MIN_GATE cycles
    generate
        if (MIN_GATE == 0) begin : g_no_min
            assign w_len_ok = 1'b1;
        end else begin : g_min
            assign w_len_ok = (r_len >= LEN_W'(MIN_GATE));
        end
    endgenerate

    // Close request while VALID without a retrigger: honoured end or watchdog expiry
`ifdef DVL_TIMEOUT_EN
    logic w_wd_expire;
    assign w_wd_expire = (r_len == LEN_W'(MAX_GATE - 1));
    assign w_close     = !i_start && ((i_end && w_len_ok) || w_wd_expire);
`else
    assign w_close     = !i_start && i_end && w_len_ok;
`endif

    // State register
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_start && i_enable) begin
                    w_state_nxt = VALID;
                end
            end
            VALID: begin
                if (w_close) begin
                    w_state_nxt = (HOLDOFF == 0) ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (r_hold == HOLD_W'(HOLDOFF - 1)) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values of counters and registered outputs
    always_comb begin
        w_len_nxt  = r_len;
        w_hold_nxt = r_hold;
        w_cnt_nxt  = i_clear ? '0 : r_cnt;
        w_dv_nxt   = (w_state_nxt == VALID);
        case (r_state)
            IDLE: begin
                if (w_state_nxt == VALID) begin
                    w_len_nxt = '0;
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            VALID: begin
                if (i_start) begin
                    w_len_nxt = '0;
                end else if (w_close) begin
                    w_hold_nxt = '0;
                end else if (r_len != LEN_W'(MAX_GATE)) begin
                    w_len_nxt = r_len + LEN_W'(1);
                end
            end
            HOLD: begin
                w_hold_nxt = r_hold + HOLD_W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_len  <= '0;
            r_hold <= '0;
            r_cnt  <= '0;
            r_dv   <= 1'b0;
        end else begin
            r_len  <= w_len_nxt;
            r_hold <= w_hold_nxt;
            r_cnt  <= w_cnt_nxt;
            r_dv   <= w_dv_nxt;
        end
    end

`ifdef DVL_TIMEOUT_EN
    // Sticky watchdog flag; a same-cycle set wins over clear
    logic r_timeout;
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_timeout <= 1'b0;
        end else if ((r_state == VALID) && w_close && !(i_end && w_len_ok)) begin
            r_timeout <= 1'b1;
        end else if (i_clear) begin
            r_timeout <= 1'b0;
        end
    end
    assign o_timeout = r_timeout;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_data_valid        = r_dv;
    assign o_data_valid_next_c = w_dv_nxt;
    assign o_gate_cnt          = r_cnt;

endmodule

// File: rtl/multi_dvl_generator.sv
// Multi-channel data-valid gate generator: N_CH independent dvl_channel instances,
// flattened gate counters and a registered OR of all gates.
// Optional feature: DVL_TIMEOUT_EN enables the per-channel watchdog.
// Ports:
//  clk, reset_i   clock, asynchronous active-high reset
//  enable_i       per-channel arm (blocks new gates only)
//  start_i        per-channel gate-open request
//  end_i          per-channel gate-close request
//  clear_i        synchronous clear of gate_cnt and timeout_o
//  data_valid     registered gate per channel
//  any_valid      registered OR of all gates, coincident with data_valid
//  gate_cnt       gates opened; channel c at [c*CNT_W +: CNT_W]
//  timeout_o      sticky watchdog flag per channel
module multi_dvl_generator
    import dvl_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned LEN_W    = 16,
    parameter int unsigned MIN_GATE = 0,
    parameter int unsigned HOLDOFF  = 2,
    parameter int unsigned MAX_GATE = 65535,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset_i,
    input  logic [N_CH-1:0]       enable_i,
    input  logic [N_CH-1:0]       start_i,
    input  logic [N_CH-1:0]       end_i,
    input  logic                  clear_i,
    output logic [N_CH-1:0]       data_valid,
    output logic                  any_valid,
    output logic [N_CH*CNT_W-1:0] gate_cnt,
    output logic [N_CH-1:0]       timeout_o
);

    logic [N_CH-1:0] w_dv_nxt;
    logic            r_any_valid;

    generate
        for (genvar c = 0; c < N_CH; c++) begin : g_ch
            dvl_channel #(
                .LEN_W    (LEN_W),
                .MIN_GATE (MIN_GATE),
                .HOLDOFF  (HOLDOFF),
                .MAX_GATE (MAX_GATE),
                .CNT_W    (CNT_W)
            ) u_ch (
                .clk                 (clk),
                .reset_i             (reset_i),
                .i_enable            (enable_i[c]),
                .i_start             (start_i[c]),
                .i_end               (end_i[c]),
                .i_clear             (clear_i),
                .o_data_valid        (data_valid[c]),
                .o_data_valid_next_c (w_dv_nxt[c]),
                .o_gate_cnt          (gate_cnt[c*CNT_W +: CNT_W]),
                .o_timeout           (timeout_o[c])
            );
        end
    endgenerate

    // Built from next-state gates so it lines up with the registered data_valid bits
    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            r_any_valid <= 1'b0;
        end else begin
            r_any_valid <= |w_dv_nxt;
        end
    end

    assign any_valid = r_any_valid;

endmodule

// File: tb/tb_multi_dvl_generator.sv
// Testbench for multi_dvl_generator: directed steps followed by random traffic,
// all checked against a gate-level-agnostic reference model (open flag, gate age,
// remaining hold-off) evaluated once per clock.
module tb_multi_dvl_generator;

    localparam int unsigned N_CH     = 4;
    localparam int unsigned LEN_W    = 8;
    localparam int unsigned MIN_GATE = 2;
    localparam int unsigned HOLDOFF  = 2;
    localparam int unsigned MAX_GATE = 12;
    localparam int unsigned CNT_W    = 3;

`ifdef DVL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset_i;
    logic [N_CH-1:0]       enable_i;
    logic [N_CH-1:0]       start_i;
    logic [N_CH-1:0]       end_i;
    logic                  clear_i;
    logic [N_CH-1:0]       data_valid;
    logic                  any_valid;
    logic [N_CH*CNT_W-1:0] gate_cnt;
    logic [N_CH-1:0]       timeout_o;

    always #5 clk = ~clk;

    multi_dvl_generator #(
        .N_CH     (N_CH),
        .LEN_W    (LEN_W),
        .MIN_GATE (MIN_GATE),
        .HOLDOFF  (HOLDOFF),
        .MAX_GATE (MAX_GATE),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .reset_i    (reset_i),
        .enable_i   (enable_i),
        .start_i    (start_i),
        .end_i      (end_i),
        .clear_i    (clear_i),
        .data_valid (data_valid),
        .any_valid  (any_valid),
        .gate_cnt   (gate_cnt),
        .timeout_o  (timeout_o)
    );

    // Reference model state
    bit m_open [N_CH];
    int m_age  [N_CH];
    int m_hold [N_CH];
    int m_cnt  [N_CH];
    bit m_to   [N_CH];

    int n_err = 0;
    int n_chk = 0;

    function automatic void model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_open[c] = 0; m_age[c] = 0; m_hold[c] = 0; m_cnt[c] = 0; m_to[c] = 0;
        end
    endfunction

    // One clock of behaviour, using the inputs sampled at that edge
    function automatic void model_step();
        for (int c = 0; c < N_CH; c++) begin
            bit inc    = 0;
            bit to_set = 0;
            if (m_open[c]) begin
                if (start_i[c]) begin
                    m_age[c] = 0;
                end else if (end_i[c] && m_age[c] >= int'(MIN_GATE)) begin
                    m_open[c] = 0;
                    m_hold[c] = HOLDOFF;
                end else if (TO_EN && m_age[c] == int'(MAX_GATE) - 1) begin
                    m_open[c] = 0;
                    m_hold[c] = HOLDOFF;
                    to_set    = 1;
                end else if (m_age[c] < int'(MAX_GATE)) begin
                    m_age[c]++;
                end
            end else if (m_hold[c] > 0) begin
                m_hold[c]--;
            end else if (start_i[c] && enable_i[c]) begin
                m_open[c] = 1;
                m_age[c]  = 0;
                inc       = 1;
            end
            if (inc)          m_cnt[c] = (m_cnt[c] + 1) % (1 << CNT_W);
            else if (clear_i) m_cnt[c] = 0;
            if (to_set)       m_to[c] = 1;
            else if (clear_i) m_to[c] = 0;
        end
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [N_CH-1:0]       e_dv;
        logic [N_CH-1:0]       e_to;
        logic [N_CH*CNT_W-1:0] e_cnt;
        for (int c = 0; c < N_CH; c++) begin
            e_dv[c]                = m_open[c];
            e_to[c]                = m_to[c];
            e_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        end
        chk({tag, ".data_valid"}, 64'(data_valid), 64'(e_dv));
        chk({tag, ".any_valid"},  64'(any_valid),  64'(|e_dv));
        chk({tag, ".gate_cnt"},   64'(gate_cnt),   64'(e_cnt));
        chk({tag, ".timeout"},    64'(timeout_o),  64'(e_to));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check just after it
    task automatic cyc(input logic [N_CH-1:0] st, input logic [N_CH-1:0] ed,
                       input logic clr, input string tag);
        start_i = st;
        end_i   = ed;
        clear_i = clr;
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        reset_i  = 1'b1;
        enable_i = '0;
        start_i  = '0;
        end_i    = '0;
        clear_i  = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        reset_i  = 1'b0;
        enable_i = '1;

        // Basic gate on ch0 with hold-off and reopen
        cyc(4'b0001, 4'b0000, 1'b0, "open0");
        chk("open0_dv_rises", 64'(data_valid[0]), 64'd1);
        for (int i = 0; i < 4; i++) cyc(4'b0000, 4'b0000, 1'b0, "valid0");
        cyc(4'b0000, 4'b0001, 1'b0, "end0");
        chk("end0_dv_falls", 64'(data_valid[0]), 64'd0);
        cyc(4'b0001, 4'b0000, 1'b0, "hold_start_a");
        cyc(4'b0001, 4'b0000, 1'b0, "hold_start_b");
        chk("hold_ignores_start", 64'(data_valid[0]), 64'd0);
        cyc(4'b0001, 4'b0000, 1'b0, "reopen0");
        chk("reopen0_cnt", 64'(gate_cnt[CNT_W-1:0]), 64'd2);

        // Minimum gate length: early ends ignored
        cyc(4'b0000, 4'b0001, 1'b0, "early_end_a");
        cyc(4'b0000, 4'b0001, 1'b0, "early_end_b");
        chk("min_gate_holds", 64'(data_valid[0]), 64'd1);
        cyc(4'b0000, 4'b0001, 1'b0, "min_end");
        for (int i = 0; i < 3; i++) cyc(4'b0000, 4'b0000, 1'b0, "idle");

        // Retrigger: start&end together restarts length, count unchanged
        cyc(4'b0001, 4'b0000, 1'b0, "rt_open");
        cyc(4'b0000, 4'b0000, 1'b0, "rt_v");
        cyc(4'b0001, 4'b0001, 1'b0, "rt_both");
        cyc(4'b0000, 4'b0001, 1'b0, "rt_end_a");
        cyc(4'b0000, 4'b0001, 1'b0, "rt_end_b");
        chk("retrigger_dv", 64'(data_valid[0]), 64'd1);
        chk("retrigger_cnt", 64'(gate_cnt[CNT_W-1:0]), 64'd3);
        cyc(4'b0000, 4'b0001, 1'b0, "rt_end_c");
        for (int i = 0; i < 3; i++) cyc(4'b0000, 4'b0000, 1'b0, "idle");

        // Long gate on ch1: watchdog closes it when built in
        cyc(4'b0010, 4'b0000, 1'b0, "wd_open");
        for (int i = 0; i < int'(MAX_GATE) + 3; i++) cyc(4'b0000, 4'b0000, 1'b0, "wd_run");
        chk("wd_flag", 64'(timeout_o[1]), 64'(TO_EN));
        chk("wd_dv", 64'(data_valid[1]), 64'(!TO_EN));
        cyc(4'b0000, 4'b0000, 1'b1, "wd_clear");
        chk("wd_cleared", 64'(timeout_o), 64'd0);
        cyc(4'b0000, 4'b0010, 1'b0, "wd_close");
        for (int i = 0; i < 3; i++) cyc(4'b0000, 4'b0000, 1'b0, "idle");

        // Nine gates on ch2 only: counter wraps, other fields stay put
        for (int g = 0; g < 9; g++) begin
            cyc(4'b0100, 4'b0000, 1'b0, "ch2_open");
            chk("ch2_any_tracks", 64'(any_valid), 64'(data_valid[2]));
            cyc(4'b0000, 4'b0000, 1'b0, "ch2_v");
            cyc(4'b0000, 4'b0000, 1'b0, "ch2_v");
            cyc(4'b0000, 4'b0100, 1'b0, "ch2_end");
            cyc(4'b0000, 4'b0000, 1'b0, "ch2_hold");
            cyc(4'b0000, 4'b0000, 1'b0, "ch2_hold");
        end
        chk("ch2_wrap_cnt", 64'(gate_cnt[2*CNT_W +: CNT_W]), 64'd1);

        // Enable blocks new gates only
        enable_i = 4'b0111;
        cyc(4'b1000, 4'b0000, 1'b0, "en_blocked");
        chk("en_blocked_dv", 64'(data_valid[3]), 64'd0);
        enable_i = 4'b1111;
        cyc(4'b1000, 4'b0000, 1'b0, "en_open");
        enable_i = 4'b0000;
        for (int i = 0; i < 3; i++) cyc(4'b0000, 4'b0000, 1'b0, "en_drop");
        chk("en_drop_keeps", 64'(data_valid[3]), 64'd1);
        cyc(4'b0000, 4'b1000, 1'b0, "en_close");
        enable_i = '1;
        for (int i = 0; i < 3; i++) cyc(4'b0000, 4'b0000, 1'b0, "idle");

        // Random traffic; clear only in cycles without start requests
        for (int i = 0; i < 600; i++) begin
            logic [N_CH-1:0] st;
            logic [N_CH-1:0] ed;
            logic            clr;
            for (int c = 0; c < N_CH; c++) begin
                st[c] = ($urandom_range(0, 9) < 2);
                ed[c] = ($urandom_range(0, 9) < 3);
            end
            if ($urandom_range(0, 15) == 0) enable_i = N_CH'($urandom);
            clr = (st == '0) && ($urandom_range(0, 19) == 0);
            cyc(st, ed, clr, "rand");
        end

        // Asynchronous reset in the middle of an open gate
        enable_i = '1;
        cyc(4'b0001, 4'b0000, 1'b0, "ar_open");
        cyc(4'b0000, 4'b0000, 1'b0, "ar_valid");
        #2;
        reset_i = 1'b1;
        #1;
        chk("async_rst_dv", 64'(data_valid), 64'd0);
        chk("async_rst_any", 64'(any_valid), 64'd0);
        chk("async_rst_cnt", 64'(gate_cnt), 64'd0);
        chk("async_rst_to", 64'(timeout_o), 64'd0);
        model_reset();
        @(negedge clk);
        reset_i = 1'b0;
        cyc(4'b0000, 4'b0001, 1'b0, "after_rst_idle");
        cyc(4'b0001, 4'b0000, 1'b0, "after_rst_open");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
